// File: rtl/shift_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_unit_arbiter (with v_left_shifter)                         |
// | Brief    : Round-robin sharing of one left barrel shifter between two       |
// |            requesters; SLL/SRL in one pass, SRA/ROTL in two passes.          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+

module v_left_shifter (
    input  logic [31:0] i_a,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_y
);
    logic [31:0] w_stage [0:5];

    assign w_stage[0] = i_a;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        assign w_stage[k+1] = i_shamt[k] ? (w_stage[k] << (32'd1 << k)) : w_stage[k];
    end

    assign o_y = w_stage[5];
endmodule

module shift_unit_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [1:0]  op0,
    input  logic [31:0] a0,
    input  logic [4:0]  shamt0,
    input  logic        req1,
    input  logic [1:0]  op1,
    input  logic [31:0] a1,
    input  logic [4:0]  shamt1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] y,
    output logic        done,
    output logic        done_id,
    input  logic        ack
);
    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_rr;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [4:0]  r_s;
    logic        r_id;
    logic [31:0] r_temp;
    logic [31:0] r_y;
    logic        r_done;
    logic        r_done_id;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_right;
    logic [31:0] w_sh_in;
    logic [4:0]  w_sh_amt;
    logic [31:0] w_sh_out;
    logic [31:0] w_sh_rev;
    logic [31:0] w_p1;
    logic [31:0] w_p2;

    function automatic logic [31:0] rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Contention is resolved by r_rr: 0 favours requester 0, 1 favours requester 1.
    assign w_idle = (r_state == S_IDLE) && !reset;
    assign w_gnt0 = w_idle && req0 && (!req1 || !r_rr);
    assign w_gnt1 = w_idle && req1 && (!req0 ||  r_rr);
    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;

    assign w_right = r_op[0] ^ r_op[1];

    // Second pass: SRA shifts all-ones to build the sign mask, ROTL brings in the wrapped bits.
    always_comb begin
        w_sh_in  = r_a;
        w_sh_amt = r_s;
        if (r_state == S_P2) begin
            if (r_op == c_OP_SRA) begin
                w_sh_in = '1;
            end else begin
                w_sh_in  = rev(r_a);
                w_sh_amt = 5'd0 - r_s;
            end
        end else if (w_right) begin
            w_sh_in = rev(r_a);
        end
    end

    v_left_shifter u_shifter (
        .i_a     (w_sh_in),
        .i_shamt (w_sh_amt),
        .o_y     (w_sh_out)
    );

    assign w_sh_rev = rev(w_sh_out);
    assign w_p1     = w_right ? w_sh_rev : w_sh_out;

    always_comb begin
        w_p2 = '0;
        if (r_op == c_OP_SRA) begin
            w_p2 = r_temp | (r_a[31] ? ~w_sh_rev : 32'd0);
        end else begin
            w_p2 = (r_s == 5'd0) ? r_a : (r_temp | w_sh_rev);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr      <= RR_INIT;
            r_op      <= '0;
            r_a       <= '0;
            r_s       <= '0;
            r_id      <= 1'b0;
            r_temp    <= '0;
            r_y       <= '0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op    <= w_gnt1 ? op1    : op0;
                        r_a     <= w_gnt1 ? a1     : a0;
                        r_s     <= w_gnt1 ? shamt1 : shamt0;
                        r_id    <= w_gnt1;
                        r_state <= S_P1;
                        if (req0 && req1) r_rr <= ~r_rr;
                    end
                end
                S_P1: begin
                    if (r_op == c_OP_SLL || r_op == c_OP_SRL) begin
                        r_y       <= w_p1;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_state   <= S_DONE;
                    end else begin
                        r_temp  <= w_p1;
                        r_state <= S_P2;
                    end
                end
                S_P2: begin
                    r_y       <= w_p2;
                    r_done    <= 1'b1;
                    r_done_id <= r_id;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (ack) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign y       = r_y;
    assign done    = r_done;
    assign done_id = r_done_id;
endmodule
`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_unit_arbiter                                             |
// | Brief    : Directed bench with a cycle-level reference model of the arbiter. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_unit_arbiter;
    localparam logic RR_INIT = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, a1 = '0;
    logic [4:0]  shamt0 = '0, shamt1 = '0;
    logic        gnt0, gnt1, done, done_id;
    logic [31:0] y;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    shift_unit_arbiter #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .shamt0(shamt0),
        .req1(req1), .op1(op1), .a1(a1), .shamt1(shamt1),
        .gnt0(gnt0), .gnt1(gnt1), .y(y), .done(done), .done_id(done_id), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return (s == 5'd0) ? a : ((a << s) | (a >> (32 - int'(s))));
        endcase
    endfunction

    // Reference model: outstanding job counts down its latency, then shows as done until ack.
    int          m_cnt = 0;
    bit          m_done = 0, m_did = 0, m_rr = RR_INIT, p_id = 0, win;
    logic [31:0] m_y = '0, p_y = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_done = 0; m_y = '0; m_did = 0; m_rr = RR_INIT;
        end else if (m_done) begin
            if (ack) m_done = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_y = p_y; m_did = p_id;
            end
        end else if (req0 || req1) begin
            win   = (req0 && req1) ? m_rr : req1;
            p_id  = win;
            p_y   = win ? ref_shift(op1, a1, shamt1) : ref_shift(op0, a0, shamt0);
            m_cnt = ((win ? op1 : op0) inside {2'b10, 2'b11}) ? 2 : 1;
            if (req0 && req1) m_rr = ~m_rr;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit idle = !m_done && (m_cnt == 0) && !reset;
            chk("gnt0",    32'(gnt0),    32'(idle && req0 && (!req1 || !m_rr)));
            chk("gnt1",    32'(gnt1),    32'(idle && req1 && (!req0 ||  m_rr)));
            chk("done",    32'(done),    32'(m_done));
            chk("done_id", 32'(done_id), 32'(m_did));
            chk("y",       y,            m_y);
        end
    end

    // Entered at posedge+2 right after the grant edge.
    task automatic wait_done_ack(input logic [31:0] exp_y, input bit exp_id, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!done && lat < 12);
        chk("latency", lat, exp_lat);
        chk("lit_y", y, exp_y);
        chk("lit_done_id", 32'(done_id), 32'(exp_id));
        @(posedge clk); #2 ack = 1'b1;
        @(posedge clk); #2 ack = 1'b0;
        @(negedge clk);
        chk("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic do_op(input bit id, input logic [1:0] op, input logic [31:0] a, input logic [4:0] s,
                         input logic [31:0] exp_y, input int exp_lat);
        int waits = 0;
        @(posedge clk); #2;
        if (id) begin req1 = 1; op1 = op; a1 = a; shamt1 = s; end
        else    begin req0 = 1; op0 = op; a0 = a; shamt0 = s; end
        @(negedge clk);
        while (!(id ? gnt1 : gnt0) && waits < 20) begin @(negedge clk); waits++; end
        chk("grant_seen", 32'(id ? gnt1 : gnt0), 32'd1);
        @(posedge clk); #2 req0 = 0; req1 = 0;
        wait_done_ack(exp_y, id, exp_lat);
    endtask

    initial begin
        bit gid [4];
        int waits;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_y", y, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Both requesters held: grants alternate starting at RR_INIT.
        req0 = 1; req1 = 1; op0 = 2'b01; op1 = 2'b01;
        a0 = 32'hF000_0000; a1 = 32'hF000_0000; shamt0 = 5'd28; shamt1 = 5'd28;
        for (int k = 0; k < 4; k++) begin
            waits = 0;
            @(negedge clk);
            while (!(gnt0 || gnt1) && waits < 20) begin @(negedge clk); waits++; end
            gid[k] = gnt1;
            chk("rr_order", 32'(gid[k]), 32'(RR_INIT ^ k[0]));
            waits = 0;
            @(negedge clk);
            while (!done && waits < 20) begin @(negedge clk); waits++; end
            chk("rr_y", y, 32'h0000_000F);
            chk("rr_done_id", 32'(done_id), 32'(gid[k]));
            ack = 1'b1;
            @(posedge clk); #2 ack = 1'b0;
            if (k == 3) begin req0 = 0; req1 = 0; end
        end

        // Stray ack while idle must be ignored.
        @(posedge clk); #2 ack = 1'b1;
        @(posedge clk); #2 ack = 1'b0;

        do_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);
        do_op(1, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 3);
        do_op(1, 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 3);
        do_op(0, 2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, 3);
        do_op(1, 2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001, 3);
        do_op(0, 2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F, 2);
        do_op(1, 2'b11, 32'h1234_5678, 5'd8,  32'h3456_7812, 3);
        do_op(0, 2'b10, 32'h8000_0000, 5'd0,  32'h8000_0000, 3);

        // Contended SRA flips the pointer, then reset lands during its second pass.
        @(posedge clk); #2;
        req0 = 1; req1 = 1; op0 = 2'b10; op1 = 2'b10;
        a0 = 32'h8000_0000; a1 = 32'h8000_0000; shamt0 = 5'd4; shamt1 = 5'd4;
        @(negedge clk);
        chk("pre_rst_winner", 32'({gnt1, gnt0}), RR_INIT ? 32'd2 : 32'd1);
        @(posedge clk); #2 req0 = 0; req1 = 0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(done), 32'd0);
        end
        @(posedge clk); #2 req0 = 1; req1 = 1;
        @(negedge clk);
        chk("post_rst_winner", 32'({gnt1, gnt0}), RR_INIT ? 32'd2 : 32'd1);
        @(posedge clk); #2 req0 = 0; req1 = 0;
        wait_done_ack(32'hF800_0000, RR_INIT, 3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
`default_nettype wire
